regfile_sequencer: RTL and testbench
====================================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: CLK  input  1  rising-edge clock.
REQ-003 Port: nRST  input  1  asynchronous active-low reset.
REQ-004 Requester ports:
- wr_req  input  1  write request.
- wr_sel  input  5  destination register.
- wr_dat  input  32  write data.
- wr_ready  output  1  write accepted when wr_req & wr_ready at the clock edge.
- rd_req  input  1  read request.
- rd_sel1  input  5  read select 1.
- rd_sel2  input  5  read select 2.
- rd_ready  output  1  read accepted when rd_req & rd_ready at the clock edge.
- rd_valid  output  1  read result valid, one-cycle pulse.
- rd_dat1  output  32  read result 1.
- rd_dat2  output  32  read result 2.
REQ-005 Register-file-side ports (initiator side of register_file_if):
- WEN  output  1  write enable.
- wsel  output  5  write select.
- wdat  output  32  write data.
- rsel1  output  5  read select 1.
- rsel2  output  5  read select 2.
- rdat1  input  32  read data 1.
- rdat2  input  32  read data 2.

Function
REQ-006 The block SHALL hold a 2-entry in-order write buffer (FIFO) with count 0..2.
REQ-007 An accepted write with wr_sel==0 SHALL be discarded (not enqueued).
REQ-008 wr_ready SHALL equal (count<2).
REQ-009 Each cycle SHALL be exactly one grant type: READ, DRAIN or IDLE.
REQ-010 The register file blanks rdat while WEN=1, so a cycle SHALL never combine WEN=1 with a read capture.
REQ-011 Arbitration SHALL use the following priority (first match wins):
- count==2 -> DRAIN.
- Force flag set -> DRAIN.
- rd_req -> READ.
- count>0 -> DRAIN.
- Otherwise -> IDLE.
REQ-012 rd_ready SHALL be 1 only in cycles where the arbiter would grant READ on rd_req (count<2 and force flag clear).
REQ-013 In a READ cycle:
- WEN=0; rsel1/rsel2 = rd_sel1/rd_sel2 combinationally.
- At the edge, rd_dat1/rd_dat2 SHALL capture the resolved data.
- rd_valid SHALL be 1 for exactly the following cycle.
REQ-014 Resolved data, per port:
- Select 0 -> 0.
- Else the newest FIFO entry with matching select (entries present at start of cycle).
- Else rdat1/rdat2.
REQ-015 A write accepted in the same cycle as a READ SHALL NOT be visible to that read.
REQ-016 In a DRAIN cycle:
- WEN=1; wsel/wdat = FIFO head; rsel1/rsel2 = 0.
- The head SHALL be popped at the edge.
REQ-017 In IDLE and READ cycles, wsel, wdat and WEN SHALL be 0; in IDLE, rsel1/rsel2 SHALL be 0.
REQ-018 Simultaneous pop and push SHALL leave count unchanged and preserve order.
REQ-019 Starvation counter (3 bits), per cycle:
- Increments on READ when count>0.
- Clears on DRAIN or when count==0.
- Reaching 4 SHALL set the force flag.
- The force flag SHALL clear after the next DRAIN.
REQ-020 rd_dat1/rd_dat2 SHALL hold their last captured value when rd_valid=0.

Reset
REQ-021 On nRST low, the block SHALL immediately set:
- count=0; starvation counter=0; force flag=0.
- rd_valid=0; rd_dat1=rd_dat2=0.
- WEN=0; wsel=0; wdat=0; rsel1=rsel2=0.
REQ-022 During reset, wr_ready and rd_ready SHALL be 1.
REQ-023 Reset asserted mid-operation SHALL discard all buffered writes and any pending rd_valid.

Verification
REQ-024 Write then read:
- Stimulus: write r5=0xDEADBEEF; next cycle read rd_sel1=5.
- Response: rd_dat1=0xDEADBEEF via forward or register file; rd_valid one cycle.
REQ-025 Fill and stall:
- Stimulus: rd_req held high; writes r1=1 and r2=2.
- Response: count reaches 2, wr_ready=0, rd_ready=0.
- Next cycle is DRAIN with WEN=1, wsel=1, wdat=1.
REQ-026 Zero register:
- Stimulus: write r0=0xFFFFFFFF; then read rd_sel1=0, rd_sel2=0.
- Response: WEN never 1 for wsel=0; rd_dat1=rd_dat2=0.
REQ-027 Starvation:
- Stimulus: one buffered write r3=7; rd_req held high 6 cycles.
- Response: 4 READ grants, then DRAIN (rd_ready=0, WEN=1, wsel=3, wdat=7), then READ resumes.
REQ-028 Same-cycle write and read:
- Stimulus: r4=0x11 in the file; write r4=0x22 and read r4 in the same cycle.
- Response: rd_dat1=0x11; a later read returns 0x22.
REQ-029 Reset mid-operation:
- Stimulus: 2 writes buffered; nRST low for 1 cycle.
- Response: count=0, WEN=0, rd_valid=0 immediately; buffered writes never reach the register file.

Source files
------------

// File: rtl/regfile_sequencer_if.sv
// Signal bundles for regfile_sequencer: requester-side handshake and
// register-file-side initiator port.
interface regfile_sequencer_if;
  localparam int unsigned SEL_W = 5;
  localparam int unsigned DAT_W = 32;

  logic             wr_req;
  logic [SEL_W-1:0] wr_sel;
  logic [DAT_W-1:0] wr_dat;
  logic             wr_ready;
  logic             rd_req;
  logic [SEL_W-1:0] rd_sel1;
  logic [SEL_W-1:0] rd_sel2;
  logic             rd_ready;
  logic             rd_valid;
  logic [DAT_W-1:0] rd_dat1;
  logic [DAT_W-1:0] rd_dat2;

  modport master (
    output wr_req, wr_sel, wr_dat, rd_req, rd_sel1, rd_sel2,
    input  wr_ready, rd_ready, rd_valid, rd_dat1, rd_dat2
  );

  modport slave (
    input  wr_req, wr_sel, wr_dat, rd_req, rd_sel1, rd_sel2,
    output wr_ready, rd_ready, rd_valid, rd_dat1, rd_dat2
  );
endinterface

interface register_file_if;
  localparam int unsigned SEL_W = 5;
  localparam int unsigned DAT_W = 32;

  logic             WEN;
  logic [SEL_W-1:0] wsel;
  logic [DAT_W-1:0] wdat;
  logic [SEL_W-1:0] rsel1;
  logic [SEL_W-1:0] rsel2;
  logic [DAT_W-1:0] rdat1;
  logic [DAT_W-1:0] rdat2;

  modport master (
    output WEN, wsel, wdat, rsel1, rsel2,
    input  rdat1, rdat2
  );

  modport slave (
    input  WEN, wsel, wdat, rsel1, rsel2,
    output rdat1, rdat2
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Arbitrates a single-ported register file between buffered writes and reads,
// forwarding buffered data to reads and forcing drains when writes starve.
module regfile_sequencer (
  input  logic                CLK,
  input  logic                nRST,
  regfile_sequencer_if.slave  req,
  register_file_if.master     rf
);
  localparam int unsigned SEL_W   = 5;
  localparam int unsigned DAT_W   = 32;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned STARV_W = 3;
  localparam logic [STARV_W-1:0] STARV_LIMIT = STARV_W'(4);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [DAT_W-1:0] dat;
  } wr_entry_t;

  typedef enum logic [1:0] {
    GRANT_IDLE  = 2'd0,
    GRANT_READ  = 2'd1,
    GRANT_DRAIN = 2'd2
  } grant_e;

  // Entry 0 is always the head of the buffer.
  wr_entry_t [1:0]    fifo_q, fifo_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [STARV_W-1:0] starv_q, starv_d;
  logic               force_q, force_d;
  logic               rd_valid_q, rd_valid_d;
  logic [DAT_W-1:0]   rd_dat1_q, rd_dat1_d;
  logic [DAT_W-1:0]   rd_dat2_q, rd_dat2_d;

  grant_e grant;
  logic   wr_ready_c;
  logic   rd_ready_c;
  logic   push;

  // Newest buffered write wins over the register file; r0 always reads zero.
  function automatic logic [DAT_W-1:0] resolve(
    input logic [SEL_W-1:0] sel,
    input wr_entry_t [1:0]  fifo,
    input logic [CNT_W-1:0] cnt,
    input logic [DAT_W-1:0] file_dat
  );
    logic [DAT_W-1:0] r;
    r = file_dat;
    if (cnt >= CNT_W'(1) && fifo[0].sel == sel) r = fifo[0].dat;
    if (cnt == CNT_W'(2) && fifo[1].sel == sel) r = fifo[1].dat;
    if (sel == '0) r = '0;
    return r;
  endfunction

  assign wr_ready_c   = (count_q < CNT_W'(2));
  assign rd_ready_c   = wr_ready_c && !force_q;
  assign req.wr_ready = wr_ready_c;
  assign req.rd_ready = rd_ready_c;
  assign req.rd_valid = rd_valid_q;
  assign req.rd_dat1  = rd_dat1_q;
  assign req.rd_dat2  = rd_dat2_q;

  // Grant arbitration; reset forces IDLE so the file-side outputs read zero.
  always_comb begin
    grant = GRANT_IDLE;
    if (!nRST)                    grant = GRANT_IDLE;
    else if (count_q == CNT_W'(2)) grant = GRANT_DRAIN;
    else if (force_q)             grant = GRANT_DRAIN;
    else if (req.rd_req)          grant = GRANT_READ;
    else if (count_q != '0)       grant = GRANT_DRAIN;
  end

  always_comb begin
    rf.WEN   = 1'b0;
    rf.wsel  = '0;
    rf.wdat  = '0;
    rf.rsel1 = '0;
    rf.rsel2 = '0;
    case (grant)
      GRANT_READ: begin
        rf.rsel1 = req.rd_sel1;
        rf.rsel2 = req.rd_sel2;
      end
      GRANT_DRAIN: begin
        rf.WEN  = 1'b1;
        rf.wsel = fifo_q[0].sel;
        rf.wdat = fifo_q[0].dat;
      end
      default: ;
    endcase
  end

  always_comb begin
    fifo_d     = fifo_q;
    count_d    = count_q;
    starv_d    = starv_q;
    force_d    = force_q;
    rd_valid_d = 1'b0;
    rd_dat1_d  = rd_dat1_q;
    rd_dat2_d  = rd_dat2_q;
    push       = req.wr_req && wr_ready_c && (req.wr_sel != '0);

    // Reads resolve against entries present before this cycle's push.
    if (grant == GRANT_READ) begin
      rd_valid_d = 1'b1;
      rd_dat1_d  = resolve(req.rd_sel1, fifo_q, count_q, rf.rdat1);
      rd_dat2_d  = resolve(req.rd_sel2, fifo_q, count_q, rf.rdat2);
    end

    if (grant == GRANT_DRAIN) begin
      fifo_d[0] = fifo_q[1];
      count_d   = count_q - CNT_W'(1);
    end

    if (push) begin
      fifo_d[count_d[0]] = {req.wr_sel, req.wr_dat};
      count_d            = count_d + CNT_W'(1);
    end

    if (grant == GRANT_DRAIN || count_q == '0) starv_d = '0;
    else if (grant == GRANT_READ)              starv_d = starv_q + STARV_W'(1);

    if (grant == GRANT_DRAIN)        force_d = 1'b0;
    else if (starv_d == STARV_LIMIT) force_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fifo_q     <= '0;
      count_q    <= '0;
      starv_q    <= '0;
      force_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_dat1_q  <= '0;
      rd_dat2_q  <= '0;
    end else begin
      fifo_q     <= fifo_d;
      count_q    <= count_d;
      starv_q    <= starv_d;
      force_q    <= force_d;
      rd_valid_q <= rd_valid_d;
      rd_dat1_q  <= rd_dat1_d;
      rd_dat2_q  <= rd_dat2_d;
    end
  end
endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomized bench for regfile_sequencer against a transaction-level model of
// architectural register state plus a behavioural register file.
module tb_regfile_sequencer;
  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] dat;
  } wr_t;

  logic clk;
  logic rst_n;
  bit   rf_clr;

  regfile_sequencer_if req_if();
  register_file_if     rf_if();

  regfile_sequencer dut (
    .CLK  (clk),
    .nRST (rst_n),
    .req  (req_if),
    .rf   (rf_if)
  );

  always #5 clk = ~clk;

  // External register file: blanks read data while a write is in progress.
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_if.WEN && rf_if.wsel != 5'd0) begin
      regs[rf_if.wsel] <= rf_if.wdat;
    end
  end
  assign rf_if.rdat1 = (rf_if.WEN || rf_if.rsel1 == 5'd0) ? 32'h0 : regs[rf_if.rsel1];
  assign rf_if.rdat2 = (rf_if.WEN || rf_if.rsel2 == 5'd0) ? 32'h0 : regs[rf_if.rsel2];

  // Reference model state.
  wr_t         mq[$];
  logic [31:0] mcommit [32];
  int          m_starv;
  bit          m_force;
  logic        exp_valid;
  logic [31:0] exp_d1, exp_d2;

  int checks;
  int failures;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Value a read of sel should observe: latest accepted, non-discarded write.
  function automatic logic [31:0] m_resolve(input logic [4:0] sel);
    logic [31:0] r;
    if (sel == 5'd0) return 32'h0;
    r = mcommit[sel];
    foreach (mq[i]) if (mq[i].sel == sel) r = mq[i].dat;
    return r;
  endfunction

  // One clock cycle: drive at negedge, check combinational outputs, advance model,
  // check registered outputs after the edge, return at the next negedge.
  task automatic step(input bit wq, input logic [4:0] ws, input logic [31:0] wd,
                      input bit rq, input logic [4:0] s1, input logic [4:0] s2);
    int  cnt;
    bit  g_drain, g_read;
    wr_t head;
    req_if.wr_req  = wq;
    req_if.wr_sel  = ws;
    req_if.wr_dat  = wd;
    req_if.rd_req  = rq;
    req_if.rd_sel1 = s1;
    req_if.rd_sel2 = s2;
    #1;
    cnt     = mq.size();
    g_drain = (cnt == 2) || m_force || (!rq && cnt > 0);
    g_read  = !g_drain && rq;
    head    = '0;
    if (g_drain) head = mq[0];
    check_eq("wr_ready", 32'(req_if.wr_ready), 32'(cnt < 2));
    check_eq("rd_ready", 32'(req_if.rd_ready), 32'(cnt < 2 && !m_force));
    check_eq("wen", 32'(rf_if.WEN), 32'(g_drain));
    check_eq("wsel", 32'(rf_if.wsel), 32'(head.sel));
    check_eq("wdat", rf_if.wdat, head.dat);
    check_eq("rsel1", 32'(rf_if.rsel1), g_read ? 32'(s1) : 32'h0);
    check_eq("rsel2", 32'(rf_if.rsel2), g_read ? 32'(s2) : 32'h0);

    exp_valid = g_read;
    if (g_read) begin
      exp_d1 = m_resolve(s1);
      exp_d2 = m_resolve(s2);
    end
    if (g_drain || cnt == 0) m_starv = 0;
    else if (g_read)         m_starv++;
    if (g_drain)            m_force = 1'b0;
    else if (m_starv == 4)  m_force = 1'b1;
    if (g_drain) begin
      mcommit[head.sel] = head.dat;
      void'(mq.pop_front());
    end
    if (wq && cnt < 2 && ws != 5'd0) mq.push_back('{sel: ws, dat: wd});

    @(posedge clk);
    #1;
    check_eq("rd_valid", 32'(req_if.rd_valid), 32'(exp_valid));
    check_eq("rd_dat1", req_if.rd_dat1, exp_d1);
    check_eq("rd_dat2", req_if.rd_dat2, exp_d2);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
  endtask

  // Asynchronous reset pulse with busy inputs; effects must be immediate.
  task automatic do_reset();
    req_if.wr_req  = 1'b1;
    req_if.wr_sel  = 5'd9;
    req_if.wr_dat  = 32'h5555_AAAA;
    req_if.rd_req  = 1'b1;
    req_if.rd_sel1 = 5'd3;
    req_if.rd_sel2 = 5'd7;
    rst_n = 1'b0;
    #1;
    check_eq("rst_wr_ready", 32'(req_if.wr_ready), 32'h1);
    check_eq("rst_rd_ready", 32'(req_if.rd_ready), 32'h1);
    check_eq("rst_wen", 32'(rf_if.WEN), 32'h0);
    check_eq("rst_wsel", 32'(rf_if.wsel), 32'h0);
    check_eq("rst_wdat", rf_if.wdat, 32'h0);
    check_eq("rst_rsel1", 32'(rf_if.rsel1), 32'h0);
    check_eq("rst_rsel2", 32'(rf_if.rsel2), 32'h0);
    check_eq("rst_rd_valid", 32'(req_if.rd_valid), 32'h0);
    check_eq("rst_rd_dat1", req_if.rd_dat1, 32'h0);
    check_eq("rst_rd_dat2", req_if.rd_dat2, 32'h0);
    mq.delete();
    m_starv   = 0;
    m_force   = 1'b0;
    exp_valid = 1'b0;
    exp_d1    = 32'h0;
    exp_d2    = 32'h0;
    @(posedge clk);
    #1;
    check_eq("rst_hold_wen", 32'(rf_if.WEN), 32'h0);
    check_eq("rst_hold_valid", 32'(req_if.rd_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req_if.wr_req = 1'b0;
    req_if.rd_req = 1'b0;
  endtask

  initial begin
    logic [4:0] s1, s2, ws;
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    rst_n    = 1'b0;
    rf_clr   = 1'b1;
    for (int i = 0; i < 32; i++) mcommit[i] = 32'h0;
    m_starv   = 0;
    m_force   = 1'b0;
    exp_valid = 1'b0;
    exp_d1    = 32'h0;
    exp_d2    = 32'h0;
    req_if.wr_req  = 1'b0;
    req_if.wr_sel  = 5'd0;
    req_if.wr_dat  = 32'h0;
    req_if.rd_req  = 1'b0;
    req_if.rd_sel1 = 5'd0;
    req_if.rd_sel2 = 5'd0;
    repeat (2) @(negedge clk);
    rf_clr = 1'b0;
    do_reset();

    // Write then read with forwarding.
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0);
    check_eq("wtr_valid", 32'(req_if.rd_valid), 32'h1);
    check_eq("wtr_data", req_if.rd_dat1, 32'hDEAD_BEEF);
    idle(2);

    // Fill the buffer while reads keep winning, then forced drain.
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd0, 5'd0);
    step(1'b1, 5'd2, 32'h2, 1'b1, 5'd0, 5'd0);
    check_eq("fill_wr_ready", 32'(req_if.wr_ready), 32'h0);
    check_eq("fill_rd_ready", 32'(req_if.rd_ready), 32'h0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd2);
    idle(3);

    // Zero register writes are discarded and r0 reads as zero.
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    check_eq("zero_rd1", req_if.rd_dat1, 32'h0);
    check_eq("zero_rd2", req_if.rd_dat2, 32'h0);

    // Starvation: four reads, forced drain, then reads resume.
    step(1'b1, 5'd3, 32'h7, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd1);
    check_eq("starv_r3", regs[3], 32'h7);
    idle(1);

    // Same-cycle write is invisible to the read it races.
    step(1'b1, 5'd4, 32'h11, 1'b0, 5'd0, 5'd0);
    idle(1);
    step(1'b1, 5'd4, 32'h22, 1'b1, 5'd4, 5'd0);
    check_eq("race_old", req_if.rd_dat1, 32'h11);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0);
    check_eq("race_new", req_if.rd_dat1, 32'h22);
    idle(2);

    // Reset with two buffered writes discards them.
    step(1'b1, 5'd6, 32'hAAAA_0006, 1'b1, 5'd0, 5'd0);
    step(1'b1, 5'd7, 32'hAAAA_0007, 1'b1, 5'd0, 5'd0);
    do_reset();
    idle(3);
    check_eq("rst_drop_r6", regs[6], 32'h0);
    check_eq("rst_drop_r7", regs[7], 32'h0);

    // Randomized traffic concentrated on a few registers to exercise forwarding.
    for (int i = 0; i < 1500; i++) begin
      ws = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      s1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      s2 = 5'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), ws, $urandom(),
           ($urandom_range(0, 9) < 6), s1, s2);
      if (i == 700) do_reset();
    end
    idle(3);

    for (int i = 1; i < 32; i++) check_eq($sformatf("final_r%0d", i), regs[i], mcommit[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
